// File: rtl/switch_debounce.sv
// Two-flop synchronizer and per-channel debouncer for raw slide switches, with rise/fall/change strobes.
// Latency: DB_CYCLES+2 clocks from a pin change to the swi_db update and its one-cycle strobe.
// No backpressure: outputs are free-running registers; strobes must be taken in the cycle they appear.
module switch_debounce #(
    parameter int WIDTH     = 4,
    parameter int DB_CYCLES = 100000,
    parameter int CNT_W     = $clog2(DB_CYCLES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] prswi,
    output logic [WIDTH-1:0] swi_db,
    output logic [WIDTH-1:0] swi_rise,
    output logic [WIDTH-1:0] swi_fall,
    output logic             swi_chg
);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] state;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [WIDTH-1:0] mismatch;
    logic [WIDTH-1:0] done;

    // A channel completes when it still disagrees on the last counted clock.
    always_comb begin
        mismatch = sync2 ^ state;
        done     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            done[i] = mismatch[i] && (cnt[i] == CNT_W'(DB_CYCLES - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            state    <= '0;
            swi_rise <= '0;
            swi_fall <= '0;
            swi_chg  <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= prswi;
            sync2 <= sync1;
            for (int i = 0; i < WIDTH; i++) begin
                if (!mismatch[i] || done[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
                if (done[i]) begin
                    state[i] <= sync2[i];
                end
            end
            swi_rise <= done & sync2;
            swi_fall <= done & ~sync2;
            swi_chg  <= |done;
        end
    end

    assign swi_db = state;

endmodule
